// File: rtl/c2f_ring_fetcher.sv
// CPU-to-FPGA ring consumer: read-DMA bursts fill a local line buffer, the head is written back
// to host memory, and lines stream out in order. Define C2F_STATS_EN for burst/line/stray counters.
module c2f_ring_fetcher #(
   parameter int          RB_AWIDTH  = 10,
   parameter int          BUF_AWIDTH = 9,
   parameter int          MAX_BURST  = 16,
   parameter logic [63:0] DEST_BASE  = 64'h0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [63:0]           kmem_addr,
   input  logic [63:0]           head_wb_addr,
   input  logic [RB_AWIDTH-1:0]  tail,
   output logic [RB_AWIDTH-1:0]  head,
   input  logic                  rddm_desc_ready,
   output logic                  rddm_desc_valid,
   output logic [173:0]          rddm_desc_data,
   input  logic                  wrdm_prio_ready,
   output logic                  wrdm_prio_valid,
   output logic [173:0]          wrdm_prio_data,
   input  logic                  wr_en,
   input  logic [BUF_AWIDTH-1:0] wr_addr,
   input  logic [511:0]          wr_data,
`ifdef C2F_STATS_EN
   output logic [31:0]           stat_bursts,
   output logic [31:0]           stat_lines,
   output logic [31:0]           stat_stray,
`endif
   output logic                  out_valid,
   output logic [511:0]          out_data,
   input  logic                  out_ready
);

   localparam int NW   = $clog2(MAX_BURST) + 1;
   localparam int CW   = BUF_AWIDTH + 1;
   localparam int RING = 1 << RB_AWIDTH;
   localparam int BUFN = 1 << BUF_AWIDTH;

   typedef enum logic [1:0] {IDLE, ISSUE_RD, WAIT_DATA, ISSUE_WB} state_t;

   typedef struct packed {
      logic        imm;
      logic [18:0] rsvd;
      logic [7:0]  id;
      logic [17:0] dwords;
      logic [63:0] dst;
      logic [63:0] src;
   } desc_t;

   state_t                state, state_nx;
   desc_t                 rd_desc, wb_desc;
   logic [BUF_AWIDTH-1:0] wb_ptr, rd_ptr, rd_addr;
   logic [CW-1:0]         count;
   logic [7:0]            id;
   logic [NW-1:0]         n_lat, recv;
   logic [RB_AWIDTH-1:0]  pending, head_nx;
   logic [31:0]           n_w;
   logic                  start, done, pop, wr_ok;
   logic [511:0]          mem [BUFN];

   assign rddm_desc_data = rd_desc;
   assign wrdm_prio_data = wb_desc;
   assign pop            = out_valid && out_ready;
   assign wr_ok          = (state == WAIT_DATA) && wr_en;
   assign head_nx        = head + RB_AWIDTH'(n_lat);
   assign rd_addr        = pop ? rd_ptr + BUF_AWIDTH'(1) : rd_ptr;

   // Burst size: bounded by pending slots, burst limit, ring end, free lines and buffer end.
   always_comb begin
      pending = tail - head;
      n_w     = 32'(pending);
      if (n_w > 32'(MAX_BURST))                n_w = 32'(MAX_BURST);
      if (n_w > 32'(RING) - 32'(head))         n_w = 32'(RING) - 32'(head);
      if (n_w > 32'(BUFN) - 32'(count))        n_w = 32'(BUFN) - 32'(count);
      if (n_w > 32'(BUFN) - 32'(wb_ptr))       n_w = 32'(BUFN) - 32'(wb_ptr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx        = state;
      start           = 1'b0;
      done            = 1'b0;
      rddm_desc_valid = 1'b0;
      wrdm_prio_valid = 1'b0;
      case (state)
         IDLE: if (enable && n_w != 32'd0) begin
            start    = 1'b1;
            state_nx = ISSUE_RD;
         end
         ISSUE_RD: begin
            rddm_desc_valid = 1'b1;
            if (rddm_desc_ready) state_nx = WAIT_DATA;
         end
         WAIT_DATA: if (wr_en && recv == n_lat - NW'(1)) begin
            done     = 1'b1;
            state_nx = ISSUE_WB;
         end
         ISSUE_WB: begin
            wrdm_prio_valid = 1'b1;
            if (wrdm_prio_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         wb_ptr  <= '0;
         id      <= '0;
         n_lat   <= '0;
         recv    <= '0;
         rd_desc <= '0;
         wb_desc <= '0;
      end else begin
         if (start) begin
            n_lat   <= NW'(n_w);
            rd_desc <= '{imm: 1'b0, rsvd: '0, id: id, dwords: 18'(n_w << 4),
                         dst: DEST_BASE + (64'(wb_ptr) << 6),
                         src: kmem_addr + (64'(head) << 6)};
         end
         if (rddm_desc_valid && rddm_desc_ready) begin
            id   <= id + 8'd1;
            recv <= '0;
         end else if (wr_ok) begin
            recv <= recv + NW'(1);
         end
         if (done) begin
            head    <= head_nx;
            wb_ptr  <= wb_ptr + BUF_AWIDTH'(n_lat);
            wb_desc <= '{imm: 1'b1, rsvd: '0, id: '0, dwords: 18'd1,
                         dst: head_wb_addr, src: 64'(head_nx)};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_addr] <= wr_data;
   end

   // Output register only loads lines counted before this edge, so a line written on the
   // completing edge is never read in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         count <= count + (done ? CW'(n_lat) : CW'(0)) - CW'(pop);
         if (pop) begin
            rd_ptr <= rd_ptr + BUF_AWIDTH'(1);
            if (count > CW'(1)) out_data  <= mem[rd_addr];
            else                out_valid <= 1'b0;
         end else if (!out_valid && count != '0) begin
            out_data  <= mem[rd_addr];
            out_valid <= 1'b1;
         end
      end
   end

`ifdef C2F_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_bursts <= '0;
         stat_lines  <= '0;
         stat_stray  <= '0;
      end else begin
         if (rddm_desc_valid && rddm_desc_ready && stat_bursts != '1) stat_bursts <= stat_bursts + 32'd1;
         if (pop && stat_lines != '1)                                stat_lines  <= stat_lines + 32'd1;
         if (wr_en && state != WAIT_DATA && stat_stray != '1)        stat_stray  <= stat_stray + 32'd1;
      end
   end
`endif

endmodule

// File: doc/c2f_ring_fetcher.md
Name: c2f_ring_fetcher

Overview:
CPU-to-FPGA ring-buffer consumer; the counterpart of the FPGA-to-CPU ring writer.
- Software advances the tail via PIO. The block issues read-DMA descriptors that pull 64 B ring slots from host memory into a local line buffer.
- After each burst it advances the head and writes the new head back to host memory through the priority write-DMA queue.
- Fetched lines leave in order on a valid/ready stream toward the PDU pipeline.

Parameters:
- RB_AWIDTH, 10, log2 of ring slots (64 B each).
- BUF_AWIDTH, 9, log2 of local buffer lines.
- MAX_BURST, 16, max slots per read descriptor (power of 2, ≤ 2^BUF_AWIDTH).
- DEST_BASE, 64'h0, FPGA-side DMA address of local buffer line 0.

Ports:
- clk  in  1  block clock.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  permits new bursts.
- kmem_addr  in  64  host ring base address.
- head_wb_addr  in  64  host address for head write-back.
- tail  in  RB_AWIDTH  CPU tail pointer.
- head  out  RB_AWIDTH  current head.
- rddm_desc_ready  in  1  read-DMA descriptor ready.
- rddm_desc_valid  out  1  read-DMA descriptor valid.
- rddm_desc_data  out  174  read-DMA descriptor.
- wrdm_prio_ready  in  1  priority write-DMA ready.
- wrdm_prio_valid  out  1  priority write-DMA valid.
- wrdm_prio_data  out  174  head write-back descriptor.
- wr_en  in  1  DMA write of one line into the buffer.
- wr_addr  in  BUF_AWIDTH  buffer line index.
- wr_data  in  512  line data.
- out_valid  out  1  fetched line available.
- out_data  out  512  fetched line.
- out_ready  in  1  consumer accepts line.

Behaviour:
Reset (async):
- head, wb_ptr, rd_ptr, count, id, state=IDLE all cleared.
- rddm_desc_valid, wrdm_prio_valid, out_valid cleared.
- Descriptor data and out_data cleared to 0.

Definitions:
- pending = (tail - head) mod 2^RB_AWIDTH. tail == head means empty. Software never moves tail backwards.
- free = 2^BUF_AWIDTH - count.
- n = min(pending, MAX_BURST, 2^RB_AWIDTH - head, free, 2^BUF_AWIDTH - wb_ptr). No burst crosses the ring end or the buffer end.

Descriptor layout (both queues), unused bits 0:
- [63:0] source; [127:64] destination; [145:128] dword count; [153:146] id; [173] immediate.

State machine:
- IDLE: if enable && n != 0, latch n and go to ISSUE_RD (1 cycle). Descriptor fields:
  - src = kmem_addr + head*64
  - dst = DEST_BASE + wb_ptr*64
  - dwords = n*16
  - id = id counter (8-bit, increments per issued read descriptor, wraps)
  - immediate = 0
- ISSUE_RD: rddm_desc_valid=1; data held stable until ready. On valid&ready → WAIT_DATA, recv=0.
- WAIT_DATA: each wr_en writes buf[wr_addr] and increments recv. On the cycle the last write lands (recv reaches n):
  - head += n (mod ring); wb_ptr += n (mod buffer); count += n
  - go to ISSUE_WB
- ISSUE_WB: wrdm_prio_valid=1 with src[RB_AWIDTH-1:0] = new head, dst = head_wb_addr, dwords = 1, immediate = 1. On valid&ready → IDLE.
- Only one burst is outstanding at a time.

Output stream:
- First-word-fall-through with registered out_data/out_valid. A line is visible at most 2 cycles after its burst completes.
- Pop on out_valid&out_ready: rd_ptr++, count--.
- Pop in the same cycle as burst completion: count += n-1.
- out_data stays stable while out_valid && !out_ready.

Boundaries:
- free == 0 or pending == 0 → stay in IDLE.
- enable drop mid-burst: current burst and write-back complete, then hold IDLE.
- wr_en outside WAIT_DATA: ignored (no RAM write, no counting).
- head change is visible on the head port the cycle after completion.

Optional Feature:
C2F_STATS_EN:
- Defined: adds 32-bit outputs stat_bursts (read descriptors accepted), stat_lines (lines popped) and stat_stray (wr_en outside WAIT_DATA). Counters saturate and are cleared by rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- kmem_addr=0x1000_0000, head=0, tail=5, enable=1, ready=1 → one rddm descriptor with src 0x1000_0000, dst DEST_BASE, dwords 80, id 0. Then 5 writes; head=5; wrdm_prio immediate data 5 to head_wb_addr; 5 lines out in order.
- head=1020, tail=4 (RB_AWIDTH=10) → burst n=4 from slot 1020, then a second burst n=4 from slot 0; final head=4.
- tail=40, out_ready=0, BUF_AWIDTH=5 → bursts 16, 16 fill the buffer; no descriptor until a pop. Releasing out_ready resumes with n=min(free, …).
- rddm_desc_ready low for 10 cycles → valid held with constant data; no extra descriptor; id increments exactly once.
- enable dropped during WAIT_DATA → burst and write-back finish, then no new descriptor although pending > 0.
- rst asserted mid-WAIT_DATA (asynchronous, between edges) → all outputs 0 immediately; head=0; later wr_en is ignored until a new burst.
